// File: rtl/ab_sequence_driver.sv
// rtl/ab_sequence_driver.sv - command-driven a/b stimulus sequencer with y0/y1 capture
//
// Accepts a command (op, len) over a valid/ready handshake, drives the a/b
// pattern for len cycles, inserts GAP_CYCLES idle cycles, then pulses done.
// While driving, y0/y1 from the target FSM are sampled every cycle.
//
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   cmd_valid/cmd_ready command handshake; ready is high only in IDLE
//   cmd_op[1:0]         00 HOLD, 01 A_ONLY, 10 A_AND_B, 11 TOGGLE_A
//   cmd_len[LEN_W-1:0]  pattern length in cycles (0 behaves as 1)
//   a, b                registered stimulus to the target FSM
//   y0, y1              target FSM response
//   busy                high while driving or in the gap
//   done                one-cycle completion pulse
//   y0_count            saturating count of y0=1 cycles seen while driving
//   y1_seen             sticky flag, y1=1 seen while driving
module ab_sequence_driver #(
   parameter int LEN_W      = 4,
   parameter int CNT_W      = 8,
   parameter int GAP_CYCLES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [LEN_W-1:0] cmd_len,
   output logic             a,
   output logic             b,
   input  logic             y0,
   input  logic             y1,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] y0_count,
   output logic             y1_seen
);

   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   typedef enum logic [1:0] {IDLE, DRIVE, GAP, DONE} state_t;

   state_t            state, state_n;
   logic [1:0]        op_q, op_n;
   logic [LEN_W-1:0]  last_q, last_n;   // index of the final drive cycle (N-1)
   logic [LEN_W-1:0]  cnt_q, cnt_n;
   logic [GAP_W-1:0]  gap_q, gap_n;
   logic              a_n, b_n, busy_n, done_n, y1_seen_n;
   logic [CNT_W-1:0]  y0_count_n;

   // a/b for drive cycle k; only the parity of k matters (TOGGLE_A starts at 1)
   function automatic logic [1:0] pattern(input logic [1:0] op, input logic k0);
      case (op)
         2'b01:   pattern = 2'b10;
         2'b10:   pattern = 2'b11;
         2'b11:   pattern = {~k0, 1'b0};
         default: pattern = 2'b00;
      endcase
   endfunction

   assign cmd_ready = (state == IDLE);

   always_comb begin
      state_n    = state;
      op_n       = op_q;
      last_n     = last_q;
      cnt_n      = cnt_q;
      gap_n      = gap_q;
      a_n        = 1'b0;
      b_n        = 1'b0;
      busy_n     = 1'b0;
      done_n     = 1'b0;
      y0_count_n = y0_count;
      y1_seen_n  = y1_seen;
      case (state)
         IDLE: begin
            if (cmd_valid) begin
               state_n    = DRIVE;
               op_n       = cmd_op;
               last_n     = (cmd_len == '0) ? '0 : cmd_len - LEN_W'(1);
               cnt_n      = '0;
               {a_n, b_n} = pattern(cmd_op, 1'b0);
               busy_n     = 1'b1;
               y0_count_n = '0;
               y1_seen_n  = 1'b0;
            end
         end
         DRIVE: begin
            // Capture the response to the pattern cycle currently on a/b
            if (y0 && (y0_count != {CNT_W{1'b1}}))
               y0_count_n = y0_count + CNT_W'(1);
            if (y1)
               y1_seen_n = 1'b1;
            if (cnt_q == last_q) begin
               cnt_n = '0;
               gap_n = '0;
               if (GAP_CYCLES == 0) begin
                  state_n = DONE;
                  done_n  = 1'b1;
               end else begin
                  state_n = GAP;
                  busy_n  = 1'b1;
               end
            end else begin
               cnt_n      = cnt_q + LEN_W'(1);
               {a_n, b_n} = pattern(op_q, ~cnt_q[0]);
               busy_n     = 1'b1;
            end
         end
         GAP: begin
            if (gap_q == GAP_LAST) begin
               state_n = DONE;
               done_n  = 1'b1;
            end else begin
               gap_n  = gap_q + GAP_W'(1);
               busy_n = 1'b1;
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         op_q     <= 2'b00;
         last_q   <= '0;
         cnt_q    <= '0;
         gap_q    <= '0;
         a        <= 1'b0;
         b        <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         y0_count <= '0;
         y1_seen  <= 1'b0;
      end else begin
         state    <= state_n;
         op_q     <= op_n;
         last_q   <= last_n;
         cnt_q    <= cnt_n;
         gap_q    <= gap_n;
         a        <= a_n;
         b        <= b_n;
         busy     <= busy_n;
         done     <= done_n;
         y0_count <= y0_count_n;
         y1_seen  <= y1_seen_n;
      end
   end

endmodule

// File: tb/tb_ab_sequence_driver.sv
// tb/tb_ab_sequence_driver.sv - directed self-checking bench for ab_sequence_driver
module tb_ab_sequence_driver;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       cmd_valid = 1'b0;
   logic [1:0] cmd_op = 2'b00;
   logic [3:0] cmd_len = 4'd0;
   logic       y0 = 1'b0;
   logic       y1 = 1'b0;

   logic       cmd_ready, a, b, busy, done, y1_seen;
   logic [7:0] y0_count;
   logic       cmd_ready2, a2, b2, busy2, done2, y1_seen2;
   logic [1:0] y0_count2;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   ab_sequence_driver #(.LEN_W(4), .CNT_W(8), .GAP_CYCLES(2)) dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_len(cmd_len), .a(a), .b(b), .y0(y0), .y1(y1),
      .busy(busy), .done(done), .y0_count(y0_count), .y1_seen(y1_seen)
   );

   ab_sequence_driver #(.LEN_W(4), .CNT_W(2), .GAP_CYCLES(2)) dut2 (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready2),
      .cmd_op(cmd_op), .cmd_len(cmd_len), .a(a2), .b(b2), .y0(y0), .y1(y1),
      .busy(busy2), .done(done2), .y0_count(y0_count2), .y1_seen(y1_seen2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // advance one clock edge and settle just after it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // present a command; returns in cycle T+1 with cmd_valid dropped
   task automatic issue(input logic [1:0] op, input logic [3:0] len);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_len   = len;
      step();
      cmd_valid = 1'b0;
   endtask

   // bounded wait until the driver is back in IDLE
   task automatic wait_idle(input string tag);
      int n = 0;
      while (!cmd_ready && n < 40) begin
         step();
         n++;
      end
      chk(tag, {31'd0, cmd_ready}, 32'd1);
   endtask

   initial begin
      // Reset state
      #2;
      chk("rst_a", {31'd0, a}, 32'd0);
      chk("rst_b", {31'd0, b}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_y0cnt", {24'd0, y0_count}, 32'd0);
      chk("rst_y1seen", {31'd0, y1_seen}, 32'd0);
      step();
      step();
      reset = 1'b0;
      step();
      chk("rst_ready", {31'd0, cmd_ready}, 32'd1);

      // A_AND_B len=3: drive T+1..T+3, gap T+4..T+5, done T+6, ready T+7
      issue(2'b10, 4'd3);
      chk("ab_t1", {30'd0, a, b}, 32'd3);
      chk("ab_t1_busy", {30'd0, busy, cmd_ready}, 32'd2);
      step();
      chk("ab_t2", {30'd0, a, b}, 32'd3);
      step();
      chk("ab_t3", {30'd0, a, b}, 32'd3);
      step();
      chk("ab_t4_gap", {29'd0, a, b, busy}, 32'd1);
      step();
      chk("ab_t5_gap", {29'd0, a, b, busy}, 32'd1);
      step();
      chk("ab_t6_done", {28'd0, a, b, busy, done}, 32'd1);
      chk("ab_t6_ready", {31'd0, cmd_ready}, 32'd0);
      step();
      chk("ab_t7", {30'd0, done, cmd_ready}, 32'd1);

      // TOGGLE_A len=4: a=1,0,1,0 b=0, then gap
      issue(2'b11, 4'd4);
      chk("tog_k0", {30'd0, a, b}, 32'd2);
      step();
      chk("tog_k1", {30'd0, a, b}, 32'd0);
      step();
      chk("tog_k2", {30'd0, a, b}, 32'd2);
      step();
      chk("tog_k3", {29'd0, a, b, busy}, 32'd1);
      step();
      chk("tog_gap", {29'd0, a, b, busy}, 32'd1);
      wait_idle("tog_idle");

      // HOLD len=0 behaves as one drive cycle: done lands at T+4
      issue(2'b00, 4'd0);
      chk("hold_t1", {29'd0, a, b, busy}, 32'd1);
      step();
      step();
      chk("hold_t3", {30'd0, busy, done}, 32'd2);
      step();
      chk("hold_t4_done", {30'd0, busy, done}, 32'd1);
      step();

      // y0 tied high: A_ONLY len=5 -> 5; gap cycles are not counted
      y0 = 1'b1;
      issue(2'b01, 4'd5);
      chk("y0_clear", {24'd0, y0_count}, 32'd0);
      wait_idle("y0_idle5");
      chk("y0_cnt5", {24'd0, y0_count}, 32'd5);
      chk("y0_noy1", {31'd0, y1_seen}, 32'd0);
      chk("y0_sat_a", {30'd0, y0_count2}, 32'd3);
      issue(2'b01, 4'd7);
      wait_idle("y0_idle7");
      chk("y0_cnt7", {24'd0, y0_count}, 32'd7);
      chk("y0_sat_b", {30'd0, y0_count2}, 32'd3);
      y0 = 1'b0;

      // One-cycle y1 pulse in the second drive cycle
      issue(2'b01, 4'd4);
      chk("y1_pre", {31'd0, y1_seen}, 32'd0);
      step();
      y1 = 1'b1;
      step();
      y1 = 1'b0;
      chk("y1_set", {31'd0, y1_seen}, 32'd1);
      wait_idle("y1_idle");
      step();
      chk("y1_hold", {31'd0, y1_seen}, 32'd1);
      issue(2'b00, 4'd1);
      chk("y1_clr", {31'd0, y1_seen}, 32'd0);
      wait_idle("y1_idle2");

      // cmd_valid held, op changed mid-command: accepted only in IDLE
      issue(2'b10, 4'd2);
      cmd_valid = 1'b1;
      cmd_op    = 2'b11;
      cmd_len   = 4'd1;
      step();
      chk("hv_t2", {30'd0, a, b}, 32'd3);
      step();
      step();
      step();
      chk("hv_t5_done", {29'd0, done, a, cmd_ready}, 32'd4);
      step();
      chk("hv_t6_idle", {29'd0, cmd_ready, busy, a}, 32'd4);
      step();
      cmd_valid = 1'b0;
      chk("hv_t7_new", {28'd0, a, b, busy, cmd_ready}, 32'd10);
      step();
      chk("hv_gap", {29'd0, a, b, busy}, 32'd1);
      wait_idle("hv_idle");

      // Reset mid-DRIVE of A_AND_B: immediate abort, no done
      issue(2'b10, 4'd5);
      step();
      reset = 1'b1;
      #1;
      chk("mid_rst_ab", {30'd0, a, b}, 32'd0);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      step();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("mid_rst_idle", {29'd0, cmd_ready, busy, done}, 32'd4);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
